// File: rtl/gps_ack_peak_tracker_if.sv
// ----------------------------------------------------------------------------
// gps_ack_peak_tracker_if
//   Result stream from the acquisition peak tracker to the host /
//   tracking-handoff logic. One record per PRN, valid/ready handshake.
//
//   rd_valid       record valid (driven by tracker)
//   rd_ready       consumer accepts record (driven by consumer)
//   rd_sat         PRN of record, 1..NUM_SAT
//   rd_found       entry written and metric at or above threshold
//   rd_metric      best correlation metric for the PRN
//   rd_code_phase  code phase of best metric
//   rd_doppler     signed Doppler NCO word of best metric
//   report_done    one-cycle pulse after the last record is accepted
//
//   Modports: master = tracker side, slave = consumer side.
// ----------------------------------------------------------------------------
interface gps_ack_peak_tracker_if #(
    parameter int INTEG_W = 12
) ();
    logic               rd_valid;
    logic               rd_ready;
    logic [5:0]         rd_sat;
    logic               rd_found;
    logic [INTEG_W-1:0] rd_metric;
    logic [9:0]         rd_code_phase;
    logic [15:0]        rd_doppler;
    logic               report_done;

    modport master (
        output rd_valid,
        input  rd_ready,
        output rd_sat,
        output rd_found,
        output rd_metric,
        output rd_code_phase,
        output rd_doppler,
        output report_done
    );

    modport slave (
        input  rd_valid,
        output rd_ready,
        input  rd_sat,
        input  rd_found,
        input  rd_metric,
        input  rd_code_phase,
        input  rd_doppler,
        input  report_done
    );
endinterface

// File: rtl/gps_ack_peak_tracker.sv
// ----------------------------------------------------------------------------
// gps_ack_peak_tracker
//   Keeps, for every PRN 1..NUM_SAT, the strongest correlation seen during an
//   acquisition search (metric, code phase, Doppler word). Each rising edge of
//   corr_complete snapshots the four correlator lanes, which are then folded
//   into the table one lane per cycle. When the correlator signals
//   search_complete, the whole table is streamed out, one record per PRN.
//
//   Ports:
//     clk              system clock
//     rst              asynchronous active-low reset
//     clear            one-cycle pulse: wipe table, abort any report
//     corr_complete    level from correlator, rising edge = integrators final
//     search_complete  pulse: whole search space done, start reporting
//     code_phase       code phase of the current correlation
//     doppler_omega    signed Doppler NCO word of the current correlation
//     sat0..sat3       PRN numbers of the four lanes
//     integrator_0..3  lane correlation counts, midpoint = no correlation
//     rd_if            result stream (master modport)
//     overrun          sticky: a correlation event was lost while busy
// ----------------------------------------------------------------------------
module gps_ack_peak_tracker #(
    parameter int INTEG_W   = 12,
    parameter int THRESHOLD = 200,
    parameter int NUM_SAT   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   corr_complete,
    input  logic                   search_complete,
    input  logic [9:0]             code_phase,
    input  logic [15:0]            doppler_omega,
    input  logic [5:0]             sat0,
    input  logic [5:0]             sat1,
    input  logic [5:0]             sat2,
    input  logic [5:0]             sat3,
    input  logic [INTEG_W-1:0]     integrator_0,
    input  logic [INTEG_W-1:0]     integrator_1,
    input  logic [INTEG_W-1:0]     integrator_2,
    input  logic [INTEG_W-1:0]     integrator_3,
    gps_ack_peak_tracker_if.master rd_if,
    output logic                   overrun
);

    localparam int                 IDX_W    = $clog2(NUM_SAT);
    localparam logic [INTEG_W-1:0] MIDPOINT = {1'b1, {(INTEG_W-1){1'b0}}};
    localparam logic [INTEG_W-1:0] THR      = INTEG_W'(THRESHOLD);
    localparam logic [5:0]         LAST_PRN = 6'(NUM_SAT);

    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_UPDATE  = 2'd1;
    localparam logic [1:0] ST_REPORT  = 2'd2;

    // Distance from the no-correlation midpoint. MIDPOINT - 0 still fits in
    // INTEG_W bits, so no extra width is needed.
    function automatic logic [INTEG_W-1:0] abs_metric(input logic [INTEG_W-1:0] v);
        if (v >= MIDPOINT) return v - MIDPOINT;
        else               return MIDPOINT - v;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]         state;
    logic [1:0]         lane;
    logic               pending;
    logic               corr_q;

    logic [5:0]         snap_sat   [4];
    logic [INTEG_W-1:0] snap_integ [4];
    logic [9:0]         snap_phase;
    logic [15:0]        snap_dop;

    logic [NUM_SAT-1:0] tbl_valid;
    logic [INTEG_W-1:0] tbl_metric [NUM_SAT];
    logic [9:0]         tbl_phase  [NUM_SAT];
    logic [15:0]        tbl_dop    [NUM_SAT];

    // ------------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------------
    logic               corr_edge;
    logic [5:0]         lane_sat;
    logic [INTEG_W-1:0] lane_metric;
    logic               lane_in_range;
    logic [IDX_W-1:0]   wr_idx;
    logic               wr_en;
    logic               accept;
    logic               enter_report;
    logic               advance;
    logic               finish;
    logic [IDX_W-1:0]   ld_idx;
    logic               ld_hit;
    logic               ld_valid;
    logic [INTEG_W-1:0] ld_metric;
    logic [9:0]         ld_phase;
    logic [15:0]        ld_dop;

    assign corr_edge = corr_complete && !corr_q;

    // NOTE: every signal gets a default at the top of always_comb so that no
    // path leaves it unassigned; otherwise a latch would be inferred.
    always_comb begin
        lane_sat      = snap_sat[lane];
        lane_metric   = abs_metric(snap_integ[lane]);
        lane_in_range = (lane_sat != 6'd0) && (lane_sat <= LAST_PRN);
        wr_idx        = IDX_W'(lane_sat - 6'd1);
        // Strictly greater: on a tie the earlier correlation is kept.
        wr_en         = (state == ST_UPDATE) && lane_in_range &&
                        (!tbl_valid[wr_idx] || (lane_metric > tbl_metric[wr_idx]));

        accept        = (state == ST_REPORT) && rd_if.rd_valid && rd_if.rd_ready;
        // A simultaneous edge in COLLECT wins: the snapshot is folded in first
        // and the search_complete is remembered as pending.
        enter_report  = ((state == ST_COLLECT) && !corr_edge && search_complete) ||
                        ((state == ST_UPDATE) && (lane == 2'd3) &&
                         (pending || search_complete));
        advance       = accept && (rd_if.rd_sat != LAST_PRN);
        finish        = accept && (rd_if.rd_sat == LAST_PRN);

        // rd_sat doubles as the PRN counter; the next record is PRN rd_sat+1,
        // i.e. table index rd_sat. Entering the report always starts at PRN 1.
        ld_idx        = (state == ST_REPORT) ? IDX_W'(rd_if.rd_sat) : '0;
        // Lane 3 may write the very entry being loaded on the way into REPORT.
        ld_hit        = wr_en && (wr_idx == ld_idx);
        ld_valid      = ld_hit || tbl_valid[ld_idx];
        ld_metric     = ld_hit ? lane_metric : tbl_metric[ld_idx];
        ld_phase      = ld_hit ? snap_phase  : tbl_phase[ld_idx];
        ld_dop        = ld_hit ? snap_dop    : tbl_dop[ld_idx];
    end

    // ------------------------------------------------------------------------
    // Edge detector: runs through clear so an edge coinciding with clear is
    // consumed and not seen again afterwards.
    // ------------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) corr_q <= 1'b0;
        else      corr_q <= corr_complete;
    end

    // ------------------------------------------------------------------------
    // Snapshot register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                snap_sat[i]   <= '0;
                snap_integ[i] <= '0;
            end
            snap_phase <= '0;
            snap_dop   <= '0;
        end else if (!clear && (state == ST_COLLECT) && corr_edge) begin
            snap_sat[0]   <= sat0;
            snap_sat[1]   <= sat1;
            snap_sat[2]   <= sat2;
            snap_sat[3]   <= sat3;
            snap_integ[0] <= integrator_0;
            snap_integ[1] <= integrator_1;
            snap_integ[2] <= integrator_2;
            snap_integ[3] <= integrator_3;
            snap_phase    <= code_phase;
            snap_dop      <= doppler_omega;
        end
    end

    // ------------------------------------------------------------------------
    // Peak table
    // ------------------------------------------------------------------------
    // NOTE: the table is built from flops rather than RAM because both reset
    // and clear must wipe every entry in a single cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tbl_valid <= '0;
            for (int i = 0; i < NUM_SAT; i++) begin
                tbl_metric[i] <= '0;
                tbl_phase[i]  <= '0;
                tbl_dop[i]    <= '0;
            end
        end else if (clear) begin
            tbl_valid <= '0;
            for (int i = 0; i < NUM_SAT; i++) begin
                tbl_metric[i] <= '0;
                tbl_phase[i]  <= '0;
                tbl_dop[i]    <= '0;
            end
        end else if (wr_en) begin
            tbl_valid[wr_idx]  <= 1'b1;
            tbl_metric[wr_idx] <= lane_metric;
            tbl_phase[wr_idx]  <= snap_phase;
            tbl_dop[wr_idx]    <= snap_dop;
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_COLLECT;
            lane    <= 2'd0;
            pending <= 1'b0;
            overrun <= 1'b0;
        end else if (clear) begin
            // An edge in the same cycle is dropped silently.
            state   <= ST_COLLECT;
            lane    <= 2'd0;
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            case (state)
                ST_COLLECT: begin
                    if (corr_edge) begin
                        state   <= ST_UPDATE;
                        lane    <= 2'd0;
                        pending <= search_complete;
                    end else if (search_complete) begin
                        state <= ST_REPORT;
                    end
                end
                ST_UPDATE: begin
                    if (corr_edge) overrun <= 1'b1;
                    lane <= lane + 2'd1;
                    if (search_complete) pending <= 1'b1;
                    if (lane == 2'd3) begin
                        state   <= (pending || search_complete) ? ST_REPORT : ST_COLLECT;
                        pending <= 1'b0;
                    end
                end
                ST_REPORT: begin
                    if (corr_edge) overrun <= 1'b1;
                    if (finish) state <= ST_COLLECT;
                end
                default: state <= ST_COLLECT;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Registered result stream. Records only change on enter/accept, so the
    // outputs hold while the consumer stalls.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_if.rd_valid      <= 1'b0;
            rd_if.rd_sat        <= '0;
            rd_if.rd_found      <= 1'b0;
            rd_if.rd_metric     <= '0;
            rd_if.rd_code_phase <= '0;
            rd_if.rd_doppler    <= '0;
            rd_if.report_done   <= 1'b0;
        end else if (clear) begin
            rd_if.rd_valid      <= 1'b0;
            rd_if.rd_sat        <= '0;
            rd_if.rd_found      <= 1'b0;
            rd_if.rd_metric     <= '0;
            rd_if.rd_code_phase <= '0;
            rd_if.rd_doppler    <= '0;
            rd_if.report_done   <= 1'b0;
        end else begin
            rd_if.report_done <= 1'b0;
            if (enter_report || advance) begin
                rd_if.rd_valid      <= 1'b1;
                rd_if.rd_sat        <= enter_report ? 6'd1 : rd_if.rd_sat + 6'd1;
                rd_if.rd_found      <= ld_valid && (ld_metric >= THR);
                rd_if.rd_metric     <= ld_valid ? ld_metric : '0;
                rd_if.rd_code_phase <= ld_valid ? ld_phase  : '0;
                rd_if.rd_doppler    <= ld_valid ? ld_dop    : '0;
            end else if (finish) begin
                rd_if.rd_valid      <= 1'b0;
                rd_if.rd_sat        <= '0;
                rd_if.rd_found      <= 1'b0;
                rd_if.rd_metric     <= '0;
                rd_if.rd_code_phase <= '0;
                rd_if.rd_doppler    <= '0;
                rd_if.report_done   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gps_ack_peak_tracker.sv
// ----------------------------------------------------------------------------
// tb_gps_ack_peak_tracker
//   Self-checking bench for gps_ack_peak_tracker. A behavioural model of the
//   peak table supplies the expected 32 records of every report, which are
//   queued and compared as each record is accepted. A table of correlation
//   events also carries a hand-derived expected record for one probe PRN.
// ----------------------------------------------------------------------------
module tb_gps_ack_peak_tracker;

    localparam int INTEG_W   = 12;
    localparam int THRESHOLD = 200;
    localparam int NUM_SAT   = 32;

    typedef struct packed {
        logic [3:0][5:0]         sat;
        logic [3:0][INTEG_W-1:0] integ;
        logic [9:0]              phase;
        logic [15:0]             dop;
        int                      probe;
        logic [INTEG_W-1:0]      exp_metric;
        logic                    exp_found;
        logic [9:0]              exp_phase;
        logic [15:0]             exp_dop;
    } vec_t;

    logic               clk;
    logic               rst;
    logic               clear;
    logic               corr_complete;
    logic               search_complete;
    logic [9:0]         code_phase;
    logic [15:0]        doppler_omega;
    logic [5:0]         sat0, sat1, sat2, sat3;
    logic [INTEG_W-1:0] integrator_0, integrator_1, integrator_2, integrator_3;
    logic               overrun;

    gps_ack_peak_tracker_if #(.INTEG_W(INTEG_W)) bus ();

    gps_ack_peak_tracker #(
        .INTEG_W(INTEG_W), .THRESHOLD(THRESHOLD), .NUM_SAT(NUM_SAT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .clear          (clear),
        .corr_complete  (corr_complete),
        .search_complete(search_complete),
        .code_phase     (code_phase),
        .doppler_omega  (doppler_omega),
        .sat0           (sat0),
        .sat1           (sat1),
        .sat2           (sat2),
        .sat3           (sat3),
        .integrator_0   (integrator_0),
        .integrator_1   (integrator_1),
        .integrator_2   (integrator_2),
        .integrator_3   (integrator_3),
        .rd_if          (bus),
        .overrun        (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model of the peak table.
    logic               m_valid  [1:NUM_SAT];
    logic [INTEG_W-1:0] m_metric [1:NUM_SAT];
    logic [9:0]         m_phase  [1:NUM_SAT];
    logic [15:0]        m_dop    [1:NUM_SAT];

    logic [44:0] exp_q [$];
    logic [44:0] obs   [1:NUM_SAT];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [44:0] pack_rec(input logic [5:0] s, input logic f,
                                             input logic [INTEG_W-1:0] m,
                                             input logic [9:0] p, input logic [15:0] d);
        return {s, f, m, p, d};
    endfunction

    function automatic logic [44:0] dut_rec();
        return pack_rec(bus.rd_sat, bus.rd_found, bus.rd_metric, bus.rd_code_phase, bus.rd_doppler);
    endfunction

    function automatic logic [INTEG_W-1:0] model_metric(input logic [INTEG_W-1:0] v);
        int d;
        d = int'(v) - 2048;
        if (d < 0) d = -d;
        return INTEG_W'(d);
    endfunction

    function automatic logic [44:0] model_rec(input int p);
        if (m_valid[p])
            return pack_rec(6'(p), m_metric[p] >= THRESHOLD, m_metric[p], m_phase[p], m_dop[p]);
        return pack_rec(6'(p), 1'b0, '0, '0, '0);
    endfunction

    task automatic model_clear();
        for (int p = 1; p <= NUM_SAT; p++) begin
            m_valid[p]  = 1'b0;
            m_metric[p] = '0;
            m_phase[p]  = '0;
            m_dop[p]    = '0;
        end
    endtask

    task automatic model_apply(input vec_t v);
        int                 s;
        logic [INTEG_W-1:0] m;
        for (int l = 0; l < 4; l++) begin
            s = int'(v.sat[l]);
            if (s >= 1 && s <= NUM_SAT) begin
                m = model_metric(v.integ[l]);
                if (!m_valid[s] || m > m_metric[s]) begin
                    m_valid[s]  = 1'b1;
                    m_metric[s] = m;
                    m_phase[s]  = v.phase;
                    m_dop[s]    = v.dop;
                end
            end
        end
    endtask

    function automatic vec_t mk(input logic [5:0] s0, s1, s2, s3,
                                input logic [INTEG_W-1:0] i0, i1, i2, i3,
                                input logic [9:0] ph, input logic [15:0] dp,
                                input int probe, input logic [INTEG_W-1:0] em,
                                input logic ef, input logic [9:0] ep, input logic [15:0] ed);
        vec_t v;
        v.sat        = {s3, s2, s1, s0};
        v.integ      = {i3, i2, i1, i0};
        v.phase      = ph;
        v.dop        = dp;
        v.probe      = probe;
        v.exp_metric = em;
        v.exp_found  = ef;
        v.exp_phase  = ep;
        v.exp_dop    = ed;
        return v;
    endfunction

    task automatic drive_lanes(input vec_t v);
        sat0 = v.sat[0]; sat1 = v.sat[1]; sat2 = v.sat[2]; sat3 = v.sat[3];
        integrator_0 = v.integ[0]; integrator_1 = v.integ[1];
        integrator_2 = v.integ[2]; integrator_3 = v.integ[3];
        code_phase    = v.phase;
        doppler_omega = v.dop;
    endtask

    // Drive one corr_complete edge, then scramble the inputs so that only the
    // snapshot can supply the values folded into the table.
    task automatic fire_event(input vec_t v, input bit with_search);
        drive_lanes(v);
        corr_complete   = 1'b1;
        search_complete = with_search;
        @(negedge clk);
        corr_complete   = 1'b0;
        search_complete = 1'b0;
        drive_lanes(mk(6'd1, 6'd1, 6'd1, 6'd1, '0, '0, '0, '0, 10'h3ff, 16'hffff,
                       0, '0, 1'b0, '0, '0));
        model_apply(v);
        if (!with_search) repeat (5) @(negedge clk);
    endtask

    // Run one full report; every accepted record is compared against the
    // model queue, and stalls are checked for stable outputs.
    task automatic run_report(input bit ready_toggle, input bit started);
        int          cyc       = 0;
        int          n_acc     = 0;
        int          first_acc = -1;
        int          last_acc  = -1;
        bit          done      = 1'b0;
        bit          stalled   = 1'b0;
        logic [44:0] held      = '0;
        logic [44:0] cur;
        logic [44:0] exp;
        exp_q.delete();
        for (int p = 1; p <= NUM_SAT; p++) begin
            exp_q.push_back(model_rec(p));
            obs[p] = '0;
        end
        if (!started) begin
            search_complete = 1'b1;
            @(negedge clk);
            search_complete = 1'b0;
        end
        while (!done && cyc < 500) begin
            bus.rd_ready = ready_toggle ? (((cyc / 3) % 2) == 1) : 1'b1;
            cur = dut_rec();
            if (stalled && bus.rd_valid) check("stall_hold", cur, held);
            stalled = 1'b0;
            if (bus.report_done) begin
                check("report_done_timing", cyc, last_acc + 1);
                done = 1'b1;
            end else if (bus.rd_valid) begin
                if (bus.rd_ready) begin
                    if (exp_q.size() == 0) begin
                        check("extra_record", cur, '0);
                    end else begin
                        exp = exp_q.pop_front();
                        check("record", cur, exp);
                    end
                    if (cur[44:39] >= 6'd1 && cur[44:39] <= 6'(NUM_SAT)) obs[cur[44:39]] = cur;
                    n_acc++;
                    if (first_acc < 0) first_acc = cyc;
                    last_acc = cyc;
                end else begin
                    held    = cur;
                    stalled = 1'b1;
                end
            end
            @(negedge clk);
            cyc++;
        end
        check("report_finished", done, 1);
        check("record_count", n_acc, NUM_SAT);
        if (!ready_toggle) check("back_to_back", last_acc - first_acc, NUM_SAT - 1);
        check("rd_valid_after_done", bus.rd_valid, 0);
        check("report_done_pulse", bus.report_done, 0);
        bus.rd_ready = 1'b0;
    endtask

    vec_t vecs [8];
    vec_t v;

    initial begin
        vecs[0] = mk(6'd1, 6'd2, 6'd3, 6'd4, 12'd2048, 12'd2300, 12'd1800, 12'd2048,
                     10'd17, 16'd13, 2, 12'd252, 1'b1, 10'd17, 16'd13);
        vecs[1] = mk(6'd2, 6'd0, 6'd0, 6'd0, 12'd1796, 12'd2048, 12'd2048, 12'd2048,
                     10'd40, 16'hfffb, 2, 12'd252, 1'b1, 10'd17, 16'd13);
        vecs[2] = mk(6'd2, 6'd0, 6'd0, 6'd0, 12'd1795, 12'd2048, 12'd2048, 12'd2048,
                     10'd41, 16'hfed4, 2, 12'd253, 1'b1, 10'd41, 16'hfed4);
        vecs[3] = mk(6'd33, 6'd0, 6'd0, 6'd0, 12'd0, 12'd0, 12'd0, 12'd0,
                     10'd99, 16'd1, 3, 12'd248, 1'b1, 10'd17, 16'd13);
        vecs[4] = mk(6'd0, 6'd0, 6'd0, 6'd32, 12'd2048, 12'd2048, 12'd2048, 12'd0,
                     10'd1023, 16'h8000, 32, 12'd2048, 1'b1, 10'd1023, 16'h8000);
        vecs[5] = mk(6'd5, 6'd6, 6'd0, 6'd0, 12'd2248, 12'd1849, 12'd2048, 12'd2048,
                     10'd3, 16'h7fff, 5, 12'd200, 1'b1, 10'd3, 16'h7fff);
        vecs[6] = mk(6'd7, 6'd7, 6'd0, 6'd0, 12'd2100, 12'd4095, 12'd2048, 12'd2048,
                     10'd8, 16'h0100, 7, 12'd2047, 1'b1, 10'd8, 16'h0100);
        vecs[7] = mk(6'd0, 6'd0, 6'd0, 6'd0, 12'd2048, 12'd2048, 12'd2048, 12'd2048,
                     10'd9, 16'd9, 1, 12'd0, 1'b0, 10'd17, 16'd13);

        rst = 1'b0; clear = 1'b0; corr_complete = 1'b0; search_complete = 1'b0;
        bus.rd_ready = 1'b0;
        drive_lanes(mk('0, '0, '0, '0, '0, '0, '0, '0, '0, '0, 0, '0, 1'b0, '0, '0));
        model_clear();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        check("reset_rd_valid", bus.rd_valid, 0);
        check("reset_report_done", bus.report_done, 0);
        check("reset_overrun", overrun, 0);
        check("reset_record", dut_rec(), '0);

        // Empty table: 32 back-to-back records, nothing found.
        run_report(1'b0, 1'b0);

        // Table-driven events, each followed by a report.
        for (int i = 0; i < 8; i++) begin
            fire_event(vecs[i], 1'b0);
            run_report(i[0], 1'b0);
            check($sformatf("probe_v%0d", i), obs[vecs[i].probe],
                  pack_rec(6'(vecs[i].probe), vecs[i].exp_found, vecs[i].exp_metric,
                           vecs[i].exp_phase, vecs[i].exp_dop));
        end

        // Edge and search_complete together: the event must land in the report.
        v = mk(6'd10, 6'd0, 6'd0, 6'd0, 12'd3000, 12'd2048, 12'd2048, 12'd2048,
               10'd200, 16'h1234, 10, 12'd952, 1'b1, 10'd200, 16'h1234);
        fire_event(v, 1'b1);
        run_report(1'b0, 1'b1);
        check("simultaneous_event", obs[10], pack_rec(6'd10, 1'b1, 12'd952, 10'd200, 16'h1234));

        // Second edge two cycles after the first, while still updating.
        check("overrun_idle", overrun, 0);
        v = mk(6'd11, 6'd0, 6'd0, 6'd0, 12'd2600, 12'd2048, 12'd2048, 12'd2048,
               10'd5, 16'd7, 11, '0, 1'b0, '0, '0);
        drive_lanes(v);
        corr_complete = 1'b1;
        @(negedge clk);
        corr_complete = 1'b0;
        model_apply(v);
        drive_lanes(mk(6'd11, 6'd0, 6'd0, 6'd0, 12'd0, 12'd2048, 12'd2048, 12'd2048,
                       10'd6, 16'd6, 0, '0, 1'b0, '0, '0));
        @(negedge clk);
        corr_complete = 1'b1;
        @(negedge clk);
        corr_complete = 1'b0;
        repeat (6) @(negedge clk);
        check("overrun_set", overrun, 1);
        run_report(1'b0, 1'b0);
        check("overrun_discard", obs[11], pack_rec(6'd11, 1'b1, 12'd552, 10'd5, 16'd7));
        check("overrun_sticky", overrun, 1);

        // Clear in the middle of a report, coinciding with an edge.
        search_complete = 1'b1;
        @(negedge clk);
        search_complete = 1'b0;
        bus.rd_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("midreport_valid", bus.rd_valid, 1);
        drive_lanes(mk(6'd9, 6'd0, 6'd0, 6'd0, 12'd0, 12'd2048, 12'd2048, 12'd2048,
                       10'd1, 16'd1, 0, '0, 1'b0, '0, '0));
        clear = 1'b1;
        corr_complete = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        corr_complete = 1'b0;
        bus.rd_ready = 1'b0;
        check("clear_rd_valid", bus.rd_valid, 0);
        check("clear_overrun", overrun, 0);
        model_clear();
        repeat (6) @(negedge clk);
        check("clear_edge_dropped", overrun, 0);
        check("clear_idle_valid", bus.rd_valid, 0);
        run_report(1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Absolute time limit so a stuck design can never hang the run.
    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
